reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised multi-read-port, dual-write-port register file with a per-register busy scoreboard. It is the successor to the single-write general-purpose register file. Port A carries in-order pipeline writeback. Port B carries long-latency writeback from the image coprocessor. The scoreboard tracks registers whose coprocessor result is outstanding, so the decode stage can stall on RAW hazards.

Parameters:
BITS, 32, data width of each register
DEPTH, 32, number of registers; power of two, minimum 4
NRD, 2, number of read ports, 1 to 4
ZERO_REG, 1, when 1, register 0 is hardwired to zero
AW, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  in  1  global clock; all state updates on falling edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
rd_data  out  NRD*BITS  read data; port i at bits [i*BITS +: BITS]
rd_busy  out  NRD  scoreboard busy bit for each read address
wa_en  in  1  port A write enable (pipeline)
wa_addr  in  AW  port A destination
wa_data  in  BITS  port A data
wb_en  in  1  port B write enable (coprocessor)
wb_addr  in  AW  port B destination
wb_data  in  BITS  port B data
sb_set  in  1  mark sb_addr busy (coprocessor op issued)
sb_addr  in  AW  register to mark busy
busy_cnt  out  AW+1  number of registers currently busy
wr_conflict  out  1  registered pulse: A and B wrote the same address in one cycle

Behaviour:
- Reset (asynchronous, rst_n low):
  - all registers, busy bits, registered read data and wr_conflict clear to 0 immediately; busy_cnt = 0.
  - Reset mid-operation discards pending busy bits. No write completes on the release edge if rst_n is still low at that edge.
- Gating: when ZERO_REG = 1, any write, sb_set or busy state targeting address 0 is suppressed. Reads of address 0 return 0 with rd_busy = 0. No bypass applies to address 0.
- Writes (falling edge):
  - wa_en writes wa_data to wa_addr; wb_en writes wb_data to wb_addr.
  - Same address, both enabled: port B data wins, and wr_conflict = 1 for the next cycle (otherwise 0).
- Reads:
  - Each port registers bank[rd_addr] on the falling edge.
  - rd_data is then combinationally bypassed. If a gated write targets the port's current rd_addr this cycle, rd_data shows that write data (B over A). Otherwise it shows the registered value.
- Scoreboard (falling edge):
  - sb_set sets busy[sb_addr].
  - wb_en clears busy[wb_addr]. Port A writes never clear busy.
  - sb_set and wb_en to the same address in the same cycle: set wins, and the register stays busy.
  - sb_set to an already-busy register is allowed; it stays busy, and busy_cnt does not double-count.
- rd_busy[i]:
  - Combinational: busy[rd_addr_i], except it reads 0 when wb_en targets rd_addr_i in the same cycle without a same-cycle sb_set to that address. This is bypass-consistent with rd_data.
- busy_cnt: registered population count of the busy vector. It updates on the edge after the change, and range is 0..DEPTH.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Test Plan:
- Reset then read x1, x2: rd_data = 0 on both ports, rd_busy = 0, busy_cnt = 0. Write x0 = 0xDEAD via A: reading x0 returns 0.
- A writes x5 = 0x1234_5678 while port 0 reads x5 in the same cycle: rd_data[0] = 0x1234_5678 that cycle (bypass). The value persists on later reads.
- A writes x7 = 0x11 and B writes x7 = 0x22 in the same cycle: x7 = 0x22, wr_conflict high for exactly one cycle.
- sb_set x9 -> next cycle busy_cnt = 1 and rd_busy = 1 when reading x9. A writes x9 = 0x5: still busy. B writes x9 = 0xAB: rd_busy = 0 in the write cycle, x9 = 0xAB, busy_cnt = 0 next cycle.
- sb_set x3 with B writing x3 in the same cycle: x3 stays busy, busy_cnt = 1. Repeat sb_set x3: busy_cnt remains 1.
- Set busy on x1..x4, assert rst_n low mid-cycle: all outputs 0 immediately, without a clock edge. With NRD = 4 and BITS = 16 parameters, repeat the bypass test on all four ports.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with two write ports and a busy scoreboard.
// Port A carries in-order pipeline writeback, port B carries long-latency
// coprocessor writeback. The scoreboard marks registers whose coprocessor
// result is still outstanding so decode can stall on RAW hazards.
// All state changes on the falling edge of clk; reset is asynchronous, active-low.
module reg_file_sb #(
  parameter int BITS     = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*BITS-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [BITS-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [BITS-1:0]     wb_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic [AW:0]         busy_cnt,
  output logic                wr_conflict
);

  // True when an address may hold state (register 0 is read-only zero when ZERO_REG=1).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  // Number of set bits in a busy vector.
  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int k = 0; k < DEPTH; k++) begin
      n = n + (AW+1)'(v[k]);
    end
    return n;
  endfunction

  logic [BITS-1:0]  bank [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             wa_ok;
  logic             wb_ok;
  logic             sb_ok;

  // Writes and scoreboard sets are qualified once here; held-in-reset
  // qualification also removes any bypass while rst_n is low.
  assign wa_ok = rst_n && wa_en  && addr_ok(wa_addr);
  assign wb_ok = rst_n && wb_en  && addr_ok(wb_addr);
  assign sb_ok = rst_n && sb_set && addr_ok(sb_addr);

  // Next busy vector: coprocessor writeback clears, issue sets; set wins on a tie.
  always_comb begin
    busy_next = busy;
    if (wb_ok) busy_next[wb_addr] = 1'b0;
    if (sb_ok) busy_next[sb_addr] = 1'b1;
  end

  // Register bank: port B is assigned last so it wins a same-address write.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) bank[k] <= '0;
    end else begin
      if (wa_ok) bank[wa_addr] <= wa_data;
      if (wb_ok) bank[wb_addr] <= wb_data;
    end
  end

  // Scoreboard state, its registered population count and the write-collision flag.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      busy_cnt    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy        <= busy_next;
      busy_cnt    <= popcount(busy_next);
      wr_conflict <= wa_ok && wb_ok && (wa_addr == wb_addr);
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit_a;
    logic            hit_b;
    logic [BITS-1:0] wdata;
    logic [BITS-1:0] rd_p1;

    assign ra    = rd_addr[i*AW +: AW];
    assign hit_a = wa_ok && (wa_addr == ra);
    assign hit_b = wb_ok && (wb_addr == ra);
    assign wdata = hit_b ? wb_data : wa_data;

    // Registered read captures the post-write contents so a bypassed value
    // keeps showing once the write has retired.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_p1 <= '0;
      end else begin
        rd_p1 <= (hit_a || hit_b) ? wdata : bank[ra];
      end
    end

    assign rd_data[i*BITS +: BITS] = (hit_a || hit_b) ? wdata : rd_p1;
    // A retiring coprocessor result clears busy early unless it is re-issued this cycle.
    assign rd_busy[i] = busy[ra] && !(hit_b && !(sb_ok && (sb_addr == ra)));
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;

  // Default instance: BITS=32, DEPTH=32, NRD=2
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en, wb_en, sb_set;
  logic [4:0]  wa_addr, wb_addr, sb_addr;
  logic [31:0] wa_data, wb_data;
  logic [5:0]  busy_cnt;
  logic        wr_conflict;

  // Wide-read instance: BITS=16, NRD=4
  logic [19:0] u2_rd_addr;
  logic [63:0] u2_rd_data;
  logic [3:0]  u2_rd_busy;
  logic        u2_wa_en, u2_wb_en, u2_sb_set;
  logic [4:0]  u2_wa_addr, u2_wb_addr, u2_sb_addr;
  logic [15:0] u2_wa_data, u2_wb_data;
  logic [5:0]  u2_busy_cnt;
  logic        u2_wr_conflict;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  logic [31:0] m_rd [2];
  int          m_cnt;
  bit          m_conf;

  reg_file_sb u1 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_cnt(busy_cnt), .wr_conflict(wr_conflict)
  );

  reg_file_sb #(.BITS(16), .DEPTH(32), .NRD(4), .ZERO_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(u2_rd_addr), .rd_data(u2_rd_data), .rd_busy(u2_rd_busy),
    .wa_en(u2_wa_en), .wa_addr(u2_wa_addr), .wa_data(u2_wa_data),
    .wb_en(u2_wb_en), .wb_addr(u2_wb_addr), .wb_data(u2_wb_data),
    .sb_set(u2_sb_set), .sb_addr(u2_sb_addr),
    .busy_cnt(u2_busy_cnt), .wr_conflict(u2_wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_cnt   = 0;
    m_conf  = 1'b0;
  endtask

  // One cycle on u1: drive after the rising edge, check before the falling
  // (active) edge, then advance the model to what that edge should produce.
  task automatic step(input bit ae, input int aa, input logic [31:0] ad,
                      input bit be, input int ba, input logic [31:0] bd,
                      input bit ss, input int sa, input int r0, input int r1);
    logic [31:0] nmem [32];
    bit ok_a, ok_b, ok_s, written;
    int r;
    logic [31:0] exp_d;
    bit exp_b;
    @(posedge clk);
    #1;
    wa_en = ae; wa_addr = aa[4:0]; wa_data = ad;
    wb_en = be; wb_addr = ba[4:0]; wb_data = bd;
    sb_set = ss; sb_addr = sa[4:0];
    rd_addr = {r1[4:0], r0[4:0]};
    #1;
    ok_a = ae && (aa != 0);
    ok_b = be && (ba != 0);
    ok_s = ss && (sa != 0);
    nmem = m_mem;
    if (ok_a) nmem[aa] = ad;
    if (ok_b) nmem[ba] = bd;
    for (int i = 0; i < 2; i++) begin
      r = (i == 0) ? r0 : r1;
      written = (ok_a && aa == r) || (ok_b && ba == r);
      exp_d = written ? nmem[r] : m_rd[i];
      exp_b = (ok_b && ba == r && !(ok_s && sa == r)) ? 1'b0 : m_busy[r];
      chk($sformatf("rd_data%0d", i), rd_data[i*32 +: 32], exp_d);
      chk($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(exp_b));
    end
    chk("busy_cnt", 32'(busy_cnt), 32'(m_cnt));
    chk("wr_conflict", 32'(wr_conflict), 32'(m_conf));
    m_mem = nmem;
    if (ok_b) m_busy[ba] = 1'b0;
    if (ok_s) m_busy[sa] = 1'b1;
    m_rd[0] = nmem[r0];
    m_rd[1] = nmem[r1];
    m_cnt = 0;
    for (int k = 0; k < 32; k++) m_cnt += int'(m_busy[k]);
    m_conf = ok_a && ok_b && (aa == ba);
  endtask

  task automatic idle(input int r0, input int r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  function automatic int pick();
    return ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 8);
  endfunction

  task automatic u2_cycle(input bit ae, input int aa, input logic [15:0] ad,
                          input bit be, input int ba, input logic [15:0] bd, input int r);
    @(posedge clk);
    #1;
    u2_wa_en = ae; u2_wa_addr = aa[4:0]; u2_wa_data = ad;
    u2_wb_en = be; u2_wb_addr = ba[4:0]; u2_wb_data = bd;
    u2_rd_addr = {4{r[4:0]}};
    #1;
  endtask

  task automatic u2_all(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_p%0d", tag, i), {16'h0, u2_rd_data[i*16 +: 16]}, {16'h0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    wa_en = 0; wa_addr = 0; wa_data = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    sb_set = 0; sb_addr = 0; rd_addr = '0;
    u2_wa_en = 0; u2_wa_addr = 0; u2_wa_data = 0; u2_wb_en = 0; u2_wb_addr = 0;
    u2_wb_data = 0; u2_sb_set = 0; u2_sb_addr = 0; u2_rd_addr = '0;
    model_reset();
    #1;
    chk("rst_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state through reads of x1, x2; writes to x0 are discarded
    idle(1, 2);
    chk("rd_x1", rd_data[31:0], 32'h0);
    chk("rd_x2", rd_data[63:32], 32'h0);
    step(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_write_byp", rd_data[31:0], 32'h0);
    idle(0, 0);
    chk("x0_read", rd_data[31:0], 32'h0);

    // Same-cycle bypass of a port A write, then persistence
    step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 5, 1);
    chk("byp_x5", rd_data[31:0], 32'h1234_5678);
    idle(5, 5);
    chk("x5_after", rd_data[31:0], 32'h1234_5678);
    idle(5, 5);
    chk("x5_later", rd_data[63:32], 32'h1234_5678);

    // A and B on the same address: B wins, one-cycle conflict pulse
    step(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);
    chk("byp_conflict", rd_data[31:0], 32'h22);
    idle(7, 7);
    chk("conflict_pulse", 32'(wr_conflict), 32'h1);
    chk("x7_value", rd_data[31:0], 32'h22);
    idle(7, 7);
    chk("conflict_drop", 32'(wr_conflict), 32'h0);

    // Scoreboard life cycle on x9
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    idle(9, 9);
    chk("x9_cnt", 32'(busy_cnt), 32'h1);
    chk("x9_busy", 32'(rd_busy[0]), 32'h1);
    step(1, 9, 32'h5, 0, 0, 0, 0, 0, 9, 9);
    chk("x9_busy_after_a", 32'(rd_busy[0]), 32'h1);
    step(0, 0, 0, 1, 9, 32'hAB, 0, 0, 9, 9);
    chk("x9_busy_wb_cycle", 32'(rd_busy[0]), 32'h0);
    chk("x9_wb_byp", rd_data[31:0], 32'hAB);
    idle(9, 9);
    chk("x9_cnt_clear", 32'(busy_cnt), 32'h0);

    // Set and clear on the same address: set wins; re-set does not double-count
    step(0, 0, 0, 1, 3, 32'h77, 1, 3, 3, 3);
    idle(3, 3);
    chk("x3_busy", 32'(rd_busy[0]), 32'h1);
    chk("x3_cnt", 32'(busy_cnt), 32'h1);
    step(0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
    idle(3, 3);
    chk("x3_cnt_reset", 32'(busy_cnt), 32'h1);

    // Busy on x1..x4, then asynchronous reset between edges
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 4);
    step(0, 0, 0, 0, 0, 0, 1, 2, 1, 4);
    step(0, 0, 0, 0, 0, 0, 1, 4, 1, 4);
    idle(1, 4);
    chk("x1_4_cnt", 32'(busy_cnt), 32'h4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_data0", rd_data[31:0], 32'h0);
    chk("arst_rd_data1", rd_data[63:32], 32'h0);
    chk("arst_rd_busy", 32'(rd_busy), 32'h0);
    chk("arst_busy_cnt", 32'(busy_cnt), 32'h0);
    chk("arst_conflict", 32'(wr_conflict), 32'h0);
    chk("arst_u2", u2_rd_data[31:0] | u2_rd_data[63:32], 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1, 4);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom % 2), pick(), $urandom,
           bit'($urandom % 2), pick(), $urandom,
           bit'($urandom % 3 == 0), pick(), pick(), pick());
    end
    idle(0, 0);

    // Four-port, 16-bit instance: bypass on every port
    u2_cycle(1, 5, 16'h1234, 0, 0, 0, 5);
    u2_all("u2_byp_a", 16'h1234);
    u2_cycle(1, 6, 16'h1111, 1, 6, 16'hBEEF, 6);
    u2_all("u2_byp_b", 16'hBEEF);
    u2_cycle(0, 0, 0, 0, 0, 0, 5);
    chk("u2_conflict", 32'(u2_wr_conflict), 32'h1);
    u2_cycle(0, 0, 0, 0, 0, 0, 5);
    u2_all("u2_x5", 16'h1234);
    u2_cycle(0, 0, 0, 0, 0, 0, 6);
    u2_cycle(0, 0, 0, 0, 0, 0, 6);
    u2_all("u2_x6", 16'hBEEF);
    chk("u2_conflict_drop", 32'(u2_wr_conflict), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
